accumulator: RTL and testbench

ACCUMULATOR -- requirements
Module: accumulator

---
 rtl/accumulator.sv | 96 +++++++++
 tb/tb_accumulator.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accumulator.sv
// Signed group accumulator with valid/ready input and output handshakes.
// Sums terms until in_last, then holds the result until downstream takes it.
module accumulator #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 overflow
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  localparam int MSB = ACC_WIDTH - 1;

  state_t               state;
  logic [ACC_WIDTH-1:0] sum;
  logic                 sticky;
  logic [ACC_WIDTH-1:0] ext;
  logic [ACC_WIDTH-1:0] nsum;
  logic                 add_ovf;
  logic                 nsticky;
  logic                 acc;

  assign in_ready = (state != HOLD) && !clear;
  assign acc      = in_valid && in_ready;
  assign ext      = {{(ACC_WIDTH-WIDTH){in_data[WIDTH-1]}}, in_data};
  assign nsum     = sum + ext;
  assign add_ovf  = (sum[MSB] == ext[MSB]) &&
                    (nsum[MSB] != sum[MSB]);
  assign nsticky  = sticky | add_ovf;

  // Group FSM: sum terms, latch result on last, release on take.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sum       <= '0;
      sticky    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
    end else begin
      unique case (state)
        IDLE, ACCUM: begin
          if (clear) begin
            state  <= IDLE;
            sum    <= '0;
            sticky <= 1'b0;
          end else if (acc) begin
            sum    <= nsum;
            sticky <= nsticky;
            if (in_last) begin
              state     <= HOLD;
              out_valid <= 1'b1;
              out_data  <= nsum;
              overflow  <= nsticky;
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            sum       <= '0;
            sticky    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            overflow  <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          sum       <= '0;
          sticky    <= 1'b0;
          out_valid <= 1'b0;
          out_data  <= '0;
          overflow  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accumulator.sv
// Directed bench for accumulator: default 16/24 instance plus a
// 16/17 instance for the wrap/overflow case.
module tb_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic        overflow;

  logic        v17;
  logic        rdy17;
  logic [15:0] d17;
  logic        l17;
  logic        ov17;
  logic        ordy17;
  logic [16:0] od17;
  logic        of17;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .overflow  (overflow)
  );

  accumulator #(.WIDTH(16), .ACC_WIDTH(17)) dut17 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (1'b0),
    .in_valid  (v17),
    .in_ready  (rdy17),
    .in_data   (d17),
    .in_last   (l17),
    .out_valid (ov17),
    .out_ready (ordy17),
    .out_data  (od17),
    .overflow  (of17)
  );

  task automatic send(input logic [15:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
  endtask

  task automatic send17(input logic [15:0] d, input logic last);
    v17 = 1'b1;
    d17 = d;
    l17 = last;
    @(posedge clk); #1;
    v17 = 1'b0;
    d17 = '0;
    l17 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    out_ready = 1'b0;
    v17 = 1'b0; d17 = '0; l17 = 1'b0; ordy17 = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data, overflow} !== 26'd0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b d=%h o=%b want 0",
               out_valid, out_data, overflow);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    repeat (2) @(posedge clk);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset got rdy=%b v=%b want 1 0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send(16'd100, 1'b0);
    send(-16'sd30, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 24'd0) begin
      failures++;
      $display("FAIL basic_accum got v=%b d=%h want 0 0",
               out_valid, out_data);
    end
    send(16'd5, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 24'h00004B ||
        overflow !== 1'b0) begin
      failures++;
      $display("FAIL basic_result got v=%b d=%h o=%b want 1 00004b 0",
               out_valid, out_data, overflow);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL basic_hold_rdy got %b want 0", in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 24'd0 ||
        in_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_taken got v=%b d=%h rdy=%b want 0 0 1",
               out_valid, out_data, in_ready);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(16'd7, 1'b0);
    send(16'd8, 1'b1);
    in_valid = 1'b1;
    in_data  = 16'd99;
    in_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      clear = (i == 1);
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
          out_data !== 24'd15) begin
        failures++;
        $display("FAIL bp_hold%0d got rdy=%b v=%b d=%h want 0 1 00000f",
                 i, in_ready, out_valid, out_data);
      end
      @(posedge clk); #1;
    end
    clear = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 24'd15) begin
      failures++;
      $display("FAIL bp_take_cycle got v=%b d=%h want 1 00000f",
               out_valid, out_data);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_after got v=%b rdy=%b want 0 1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_overflow();
    ordy17 = 1'b1;
    send17(16'd32767, 1'b0);
    send17(16'd32767, 1'b0);
    send17(16'd32767, 1'b1);
    checks++;
    if (ov17 !== 1'b1 || od17 !== 17'h17FFD || of17 !== 1'b1) begin
      failures++;
      $display("FAIL ovf_result got v=%b d=%h o=%b want 1 17ffd 1",
               ov17, od17, of17);
    end
    @(posedge clk); #1;
    send17(16'd1, 1'b1);
    checks++;
    if (ov17 !== 1'b1 || od17 !== 17'd1 || of17 !== 1'b0) begin
      failures++;
      $display("FAIL ovf_next got v=%b d=%h o=%b want 1 00001 0",
               ov17, od17, of17);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    send(16'hFFFF, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 24'hFFFFFF ||
        overflow !== 1'b0) begin
      failures++;
      $display("FAIL single_neg got v=%b d=%h o=%b want 1 ffffff 0",
               out_valid, out_data, overflow);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_clear();
    out_ready = 1'b1;
    send(16'd50, 1'b0);
    send(16'd60, 1'b0);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'd999;
    in_last  = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL clear_rdy got %b want 0", in_ready);
    end
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL clear_no_take got v=%b d=%h want 0",
               out_valid, out_data);
    end
    send(16'd3, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 24'd3) begin
      failures++;
      $display("FAIL clear_result got v=%b d=%h want 1 000003",
               out_valid, out_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send(16'd10, 1'b0);
    send(16'd20, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data, overflow} !== 26'd0 ||
        in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_out got v=%b d=%h rdy=%b want 0 0 1",
               out_valid, out_data, in_ready);
    end
    #3 rst_n = 1'b1;
    send(16'd4, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 24'd4) begin
      failures++;
      $display("FAIL rstmid_result got v=%b d=%h want 1 000004",
               out_valid, out_data);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(16'd9, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 24'd9) begin
      failures++;
      $display("FAIL rsthold_pre got v=%b d=%h want 1 000009",
               out_valid, out_data);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 24'd0) begin
      failures++;
      $display("FAIL rsthold_out got v=%b d=%h want 0 0",
               out_valid, out_data);
    end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rsthold_after got v=%b rdy=%b want 0 1",
               out_valid, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_single();
    test_clear();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
